// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Keymap is indexed [row][col] to match the PmodKYPD wiring.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Active-low column drive, one column low at a time.
  localparam logic [3:0] COL_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] COL_RESET       = 4'b1110;
  localparam logic [3:0] ROWS_IDLE       = 4'b1111;

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_synchronizer.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones so an idle keypad is seen during and after reset.
module row_synchronizer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] i_row,
  output logic [3:0] o_row_s
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Metastability filter: capture flop followed by a settling flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_row;
      r_sync <= r_meta;
    end
  end

  assign o_row_s = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, debounces press and release on the
// captured row, and emits the hex code with a single-cycle valid strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS       = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                   DEB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_BITS-1:0] DWELL_LAST = {SCAN_BITS{1'b1}};

  logic [3:0]           w_row_s;
  logic                 w_row_bit;
  logic [1:0]           w_col_adv;

  state_t               r_state;
  logic [SCAN_BITS-1:0] r_dwell;
  logic [DEB_W-1:0]     r_deb;
  logic [1:0]           r_col_idx;
  logic [1:0]           r_row_idx;
  logic [3:0]           r_col;
  logic [3:0]           r_key;
  logic                 r_key_valid;
  logic                 r_key_held;

  state_t               w_state_nxt;
  logic [SCAN_BITS-1:0] w_dwell_nxt;
  logic [DEB_W-1:0]     w_deb_nxt;
  logic [1:0]           w_col_idx_nxt;
  logic [1:0]           w_row_idx_nxt;
  logic [3:0]           w_key_nxt;
  logic                 w_valid_nxt;
  logic                 w_held_nxt;

  row_synchronizer u_row_sync (
    .clock   (clock),
    .reset   (reset),
    .i_row   (row),
    .o_row_s (w_row_s)
  );

  assign w_row_bit = w_row_s[r_row_idx];
  assign w_col_adv = r_col_idx + 2'd1;

  // Next-state and output decode; counters are cleared on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_dwell_nxt   = r_dwell;
    w_deb_nxt     = r_deb;
    w_col_idx_nxt = r_col_idx;
    w_row_idx_nxt = r_row_idx;
    w_key_nxt     = r_key;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_key_held;
    case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          if (w_row_s != ROWS_IDLE) begin
            w_state_nxt   = DEBOUNCE;
            w_row_idx_nxt = lowest_low_row(w_row_s);
            w_deb_nxt     = '0;
          end else begin
            w_col_idx_nxt = w_col_adv;
            w_dwell_nxt   = '0;
          end
        end else begin
          w_dwell_nxt = r_dwell + SCAN_BITS'(1);
        end
      end
      DEBOUNCE: begin
        if (!w_row_bit) begin
          if (r_deb == DEB_LAST) begin
            w_state_nxt = HELD;
            w_key_nxt   = KEYMAP[r_row_idx][r_col_idx];
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_deb_nxt   = '0;
          end else begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end else begin
          w_state_nxt   = SCAN;
          w_deb_nxt     = '0;
          w_col_idx_nxt = w_col_adv;
          w_dwell_nxt   = '0;
        end
      end
      HELD: begin
        w_held_nxt = 1'b1;
        w_deb_nxt  = '0;
        if (w_row_bit) begin
          w_state_nxt = RELEASE;
        end else begin
          w_state_nxt = HELD;
        end
      end
      RELEASE: begin
        if (w_row_bit) begin
          if (r_deb == DEB_LAST) begin
            w_state_nxt   = SCAN;
            w_held_nxt    = 1'b0;
            w_deb_nxt     = '0;
            w_col_idx_nxt = w_col_adv;
            w_dwell_nxt   = '0;
          end else begin
            w_deb_nxt = r_deb + DEB_W'(1);
          end
        end else begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt   = SCAN;
        w_dwell_nxt   = '0;
        w_deb_nxt     = '0;
        w_col_idx_nxt = 2'd0;
        w_held_nxt    = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= SCAN;
      r_dwell     <= '0;
      r_deb       <= '0;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_col       <= COL_RESET;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell     <= w_dwell_nxt;
      r_deb       <= w_deb_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_col       <= COL_PATTERN[w_col_idx_nxt];
      r_key       <= w_key_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model plus a
// scoreboard of expected key codes popped on every key_valid strobe.
module tb_keypad_scanner;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic       use_matrix = 1'b0;
  logic [3:0] row_direct = 4'b1111;
  logic       press_en   = 1'b0;
  logic [1:0] press_row  = 2'd0;
  logic [1:0] press_col  = 2'd0;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] sb[$];
  logic [3:0] col_exp [4];
  vec_t       vecs [16];

  keypad_scanner #(.SCAN_BITS(2), .DEBOUNCE_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    row = row_direct;
    if (use_matrix) begin
      row = 4'b1111;
      if (press_en && !col[press_col]) row[press_row] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe must be isolated and match the queued code.
  always @(posedge clock) begin
    #1;
    if (key_valid) begin
      n_valid++;
      check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("key_code", {28'd0, key}, {28'd0, sb.pop_front()});
      end
    end
    prev_valid = key_valid;
  end

  task automatic wait_valid(input string name);
    int start = n_valid;
    int k = 0;
    while (n_valid == start && k < 300) begin
      @(negedge clock);
      k++;
    end
    check(name, {31'd0, n_valid != start}, 32'd1);
  endtask

  task automatic wait_held_low(input string name);
    int k = 0;
    while (key_held && k < 300) begin
      @(negedge clock);
      k++;
    end
    check(name, {31'd0, key_held}, 32'd0);
  endtask

  task automatic reset_pulse(input logic [3:0] rows_after);
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    row_direct = rows_after;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    vecs[0]  = '{2'd0, 2'd0, 4'h1}; vecs[1]  = '{2'd0, 2'd1, 4'h2};
    vecs[2]  = '{2'd0, 2'd2, 4'h3}; vecs[3]  = '{2'd0, 2'd3, 4'hA};
    vecs[4]  = '{2'd1, 2'd0, 4'h4}; vecs[5]  = '{2'd1, 2'd1, 4'h5};
    vecs[6]  = '{2'd1, 2'd2, 4'h6}; vecs[7]  = '{2'd1, 2'd3, 4'hB};
    vecs[8]  = '{2'd2, 2'd0, 4'h7}; vecs[9]  = '{2'd2, 2'd1, 4'h8};
    vecs[10] = '{2'd2, 2'd2, 4'h9}; vecs[11] = '{2'd2, 2'd3, 4'hC};
    vecs[12] = '{2'd3, 2'd0, 4'h0}; vecs[13] = '{2'd3, 2'd1, 4'hF};
    vecs[14] = '{2'd3, 2'd2, 4'hE}; vecs[15] = '{2'd3, 2'd3, 4'hD};

    // Reset state, then idle scanning for 40 clocks.
    repeat (3) @(negedge clock);
    check("rst_col", {28'd0, col}, 32'he);
    check("rst_key", {28'd0, key}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
    reset = 1'b0;
    check("idle_col_0", {28'd0, col}, {28'd0, col_exp[0]});
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      check("idle_col", {28'd0, col}, {28'd0, col_exp[(i / 4) % 4]});
    end
    check("idle_no_valid", n_valid, 32'd0);

    // Every key of the keymap through the matrix model.
    use_matrix = 1'b1;
    for (int v = 0; v < 16; v++) begin
      press_row = vecs[v].r;
      press_col = vecs[v].c;
      press_en  = 1'b1;
      sb.push_back(vecs[v].code);
      wait_valid("map_valid_timeout");
      check("map_held", {31'd0, key_held}, 32'd1);
      repeat (5) @(negedge clock);
      check("map_col_frozen", {28'd0, col}, {28'd0, col_exp[vecs[v].c]});
      press_en = 1'b0;
      wait_held_low("map_release_timeout");
      check("map_key_kept", {28'd0, key}, {28'd0, vecs[v].code});
    end

    // Key '6': exact release timing and column step afterwards.
    press_row = 2'd1;
    press_col = 2'd2;
    press_en  = 1'b1;
    sb.push_back(4'h6);
    wait_valid("k6_valid_timeout");
    check("k6_col", {28'd0, col}, 32'hb);
    check("k6_key", {28'd0, key}, 32'h6);
    repeat (3) @(negedge clock);
    press_en = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (k == 10) begin
        check("k6_held_before", {31'd0, key_held}, 32'd1);
        check("k6_col_before", {28'd0, col}, 32'hb);
      end
      if (k == 11) begin
        check("k6_held_after", {31'd0, key_held}, 32'd0);
        check("k6_col_after", {28'd0, col}, 32'h7);
      end
    end

    // Press bounce on row 0 during column 0: no key, scan resumes at column 1.
    use_matrix = 1'b0;
    base = n_valid;
    reset_pulse(4'b1110);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 5) row_direct = 4'b1111;
      if (k == 7) check("bounce_col_frozen", {28'd0, col}, 32'he);
      if (k == 8) check("bounce_col_next", {28'd0, col}, 32'hd);
    end
    repeat (12) @(negedge clock);
    check("bounce_key", {28'd0, key}, 32'h0);
    check("bounce_held", {31'd0, key_held}, 32'd0);
    check("bounce_no_valid", n_valid - base, 32'd0);

    // Rows 0 and 2 together: row 0 wins; a short release glitch is absorbed.
    reset_pulse(4'b1010);
    sb.push_back(4'h1);
    wait_valid("prio_valid_timeout");
    base = n_valid;
    repeat (3) @(negedge clock);
    row_direct = 4'b1011;
    repeat (3) @(negedge clock);
    row_direct = 4'b1010;
    repeat (15) @(negedge clock);
    check("glitch_held", {31'd0, key_held}, 32'd1);
    check("glitch_key", {28'd0, key}, 32'h1);
    check("glitch_col", {28'd0, col}, 32'he);
    check("glitch_no_valid", n_valid - base, 32'd0);
    row_direct = 4'b1111;
    wait_held_low("prio_release_timeout");

    // Asynchronous reset while holding 'D', then re-acceptance of the same key.
    use_matrix = 1'b1;
    press_row  = 2'd3;
    press_col  = 2'd3;
    press_en   = 1'b1;
    sb.push_back(4'hD);
    wait_valid("d_valid_timeout");
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_col", {28'd0, col}, 32'he);
    check("async_key", {28'd0, key}, 32'h0);
    check("async_valid", {31'd0, key_valid}, 32'd0);
    check("async_held", {31'd0, key_held}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check("rel_col_0", {28'd0, col}, 32'he);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_col;
      @(negedge clock);
      exp_col = (k < 4) ? 4'b1110 : 4'b1101;
      check("rel_col_step", {28'd0, col}, {28'd0, exp_col});
    end
    base = n_valid;
    sb.push_back(4'hD);
    wait_valid("d_again_timeout");
    repeat (20) @(negedge clock);
    check("d_single_valid", n_valid - base, 32'd1);
    check("d_held", {31'd0, key_held}, 32'd1);
    press_en = 1'b0;
    wait_held_low("d_release_timeout");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
